// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: hazard inputs and stage controls between the pipeline and the hazard controller
interface pipeline_hazard_ctrl_if #(parameter int CNT_W = 32);
    logic [4:0] rs1_IF2ID, rs2_IF2ID;
    logic use_rs1_ID, use_rs2_ID;
    logic is_branch_ID, branch_taken_ID;
    logic [4:0] rd_ID2EXE, rd_EXE2MEM;
    logic Reg_W_En_ID2EXE, Reg_W_En_EXE2MEM;
    logic Mem_R_En_ID2EXE, Mem_R_En_EXE2MEM;
    logic dmem_req_EXE2MEM, dmem_ready;
    logic pc_we, IF2ID_we, ID2EXE_we, EXE2MEM_we, MEM2WB_we;
    logic IF2ID_flush, ID2EXE_bubble, MEM2WB_bubble;
    logic mem_timeout;
    logic [CNT_W-1:0] stall_cycles, flush_count, memwait_cycles;
    modport master (
        input rs1_IF2ID, rs2_IF2ID, use_rs1_ID, use_rs2_ID, is_branch_ID, branch_taken_ID,
        input rd_ID2EXE, rd_EXE2MEM, Reg_W_En_ID2EXE, Reg_W_En_EXE2MEM,
        input Mem_R_En_ID2EXE, Mem_R_En_EXE2MEM, dmem_req_EXE2MEM, dmem_ready,
        output pc_we, IF2ID_we, ID2EXE_we, EXE2MEM_we, MEM2WB_we,
        output IF2ID_flush, ID2EXE_bubble, MEM2WB_bubble,
        output mem_timeout, stall_cycles, flush_count, memwait_cycles
    );
    modport slave (
        output rs1_IF2ID, rs2_IF2ID, use_rs1_ID, use_rs2_ID, is_branch_ID, branch_taken_ID,
        output rd_ID2EXE, rd_EXE2MEM, Reg_W_En_ID2EXE, Reg_W_En_EXE2MEM,
        output Mem_R_En_ID2EXE, Mem_R_En_EXE2MEM, dmem_req_EXE2MEM, dmem_ready,
        input pc_we, IF2ID_we, ID2EXE_we, EXE2MEM_we, MEM2WB_we,
        input IF2ID_flush, ID2EXE_bubble, MEM2WB_bubble,
        input mem_timeout, stall_cycles, flush_count, memwait_cycles
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencer for the five-stage pipeline with perf counters
module pipeline_hazard_ctrl #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W = 32
) (
    input logic clk,
    input logic reset,
    pipeline_hazard_ctrl_if.master bus
);
    localparam int WW = $clog2(TIMEOUT + 1);
    typedef enum logic {RUN, MEM_WAIT} state_t;
    state_t state, state_n;
    logic m1, m2, hit_e, hit_m, load_use, br_haz, id_stall, frz, stl, fl;
    logic timeout_q;
    logic [WW-1:0] wait_cnt, wait_base, wait_inc;
    logic [CNT_W-1:0] stall_q, flush_q, memwait_q;
    always_comb begin
        m1 = bus.use_rs1_ID & (bus.rs1_IF2ID != 5'd0);
        m2 = bus.use_rs2_ID & (bus.rs2_IF2ID != 5'd0);
        hit_e = bus.Reg_W_En_ID2EXE & (m1 & (bus.rd_ID2EXE == bus.rs1_IF2ID) | m2 & (bus.rd_ID2EXE == bus.rs2_IF2ID));
        hit_m = bus.Reg_W_En_EXE2MEM & (m1 & (bus.rd_EXE2MEM == bus.rs1_IF2ID) | m2 & (bus.rd_EXE2MEM == bus.rs2_IF2ID));
        load_use = bus.Mem_R_En_ID2EXE & hit_e;
        // ALU producers reach ID through forwarding; only loads stall a branch
        br_haz = bus.is_branch_ID & (hit_e & bus.Mem_R_En_ID2EXE | hit_m & bus.Mem_R_En_EXE2MEM);
        id_stall = load_use | br_haz;
        // once timed out the pipeline stays frozen until reset
        frz = timeout_q | ~bus.dmem_ready & (state == MEM_WAIT | bus.dmem_req_EXE2MEM);
        stl = ~frz & id_stall;
        fl = ~frz & ~id_stall & bus.is_branch_ID & bus.branch_taken_ID;
    end
    always_ff @(posedge clk)
        state <= reset ? RUN : state_n;
    always_comb
        state_n = frz ? MEM_WAIT : RUN;
    always_comb begin
        bus.pc_we = ~reset & ~frz & ~id_stall;
        bus.IF2ID_we = ~reset & ~frz & ~id_stall;
        bus.ID2EXE_we = ~reset & ~frz;
        bus.EXE2MEM_we = ~reset & ~frz;
        bus.MEM2WB_we = ~reset;
        bus.IF2ID_flush = reset | fl;
        bus.ID2EXE_bubble = reset | stl;
        bus.MEM2WB_bubble = reset | frz;
    end
    // wait run restarts from zero on every entry into the freeze
    always_comb begin
        wait_base = state == RUN ? '0 : wait_cnt;
        wait_inc = wait_base == WW'(TIMEOUT) ? wait_base : wait_base + WW'(1);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= '0;
            timeout_q <= 1'b0;
            stall_q <= '0;
            flush_q <= '0;
            memwait_q <= '0;
        end else begin
            wait_cnt <= frz ? wait_inc : '0;
            timeout_q <= timeout_q | frz & (wait_inc == WW'(TIMEOUT));
            stall_q <= stl & ~&stall_q ? stall_q + CNT_W'(1) : stall_q;
            flush_q <= fl & ~&flush_q ? flush_q + CNT_W'(1) : flush_q;
            memwait_q <= frz & ~&memwait_q ? memwait_q + CNT_W'(1) : memwait_q;
        end
    end
    assign bus.mem_timeout = timeout_q;
    assign bus.stall_cycles = stall_q;
    assign bus.flush_count = flush_q;
    assign bus.memwait_cycles = memwait_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed vectors with a per-cycle reference model and literal spot checks
module tb_pipeline_hazard_ctrl;
    localparam int TO = 8;
    localparam int CW = 4;
    localparam int MAX = (1 << CW) - 1;
    logic clk = 1'b0;
    logic reset;
    int vecs = 0, errs = 0;
    pipeline_hazard_ctrl_if #(.CNT_W(CW)) bus();
    pipeline_hazard_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) u_dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        vecs++;
        if (a !== e) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
        end
    endtask
    bit armed = 0, mw, to;
    int sc, fc, mc, run;
    bit m1, m2, eh, mh, stl, frz;
    logic [7:0] ectl, actl;
    // reference: evaluate the rules at mid-cycle, then advance the model past the coming edge
    always @(negedge clk) begin
        m1 = bus.use_rs1_ID && bus.rs1_IF2ID != 0;
        m2 = bus.use_rs2_ID && bus.rs2_IF2ID != 0;
        eh = bus.Reg_W_En_ID2EXE && ((m1 && bus.rd_ID2EXE == bus.rs1_IF2ID) || (m2 && bus.rd_ID2EXE == bus.rs2_IF2ID));
        mh = bus.Reg_W_En_EXE2MEM && ((m1 && bus.rd_EXE2MEM == bus.rs1_IF2ID) || (m2 && bus.rd_EXE2MEM == bus.rs2_IF2ID));
        stl = (bus.Mem_R_En_ID2EXE && eh) || (bus.is_branch_ID && ((eh && bus.Mem_R_En_ID2EXE) || (mh && bus.Mem_R_En_EXE2MEM)));
        frz = to || (!bus.dmem_ready && (mw || bus.dmem_req_EXE2MEM));
        ectl = reset ? 8'b0000_0111 : {!frz && !stl, !frz && !stl, !frz, !frz, 1'b1,
                                       !frz && !stl && bus.is_branch_ID && bus.branch_taken_ID, !frz && stl, frz};
        actl = {bus.pc_we, bus.IF2ID_we, bus.ID2EXE_we, bus.EXE2MEM_we, bus.MEM2WB_we,
                bus.IF2ID_flush, bus.ID2EXE_bubble, bus.MEM2WB_bubble};
        chk("ctl", 32'(actl), 32'(ectl));
        if (armed) begin
            chk("stall_cycles", 32'(bus.stall_cycles), sc);
            chk("flush_count", 32'(bus.flush_count), fc);
            chk("memwait_cycles", 32'(bus.memwait_cycles), mc);
            chk("mem_timeout", 32'(bus.mem_timeout), 32'(to));
        end
        if (reset) begin
            sc = 0; fc = 0; mc = 0; run = 0; mw = 0; to = 0; armed = 1;
        end else begin
            if (!frz && stl) sc = sc < MAX ? sc + 1 : sc;
            if (!frz && !stl && bus.is_branch_ID && bus.branch_taken_ID) fc = fc < MAX ? fc + 1 : fc;
            if (frz) mc = mc < MAX ? mc + 1 : mc;
            run = frz ? run + 1 : 0;
            if (run >= TO) to = 1;
            mw = frz;
        end
    end
    task automatic drv(input logic [4:0] r1, r2, input logic u1, u2, br, tk,
                       input logic [4:0] de, dm, input logic we, wm, le, lm, rq, rd);
        bus.rs1_IF2ID = r1; bus.rs2_IF2ID = r2; bus.use_rs1_ID = u1; bus.use_rs2_ID = u2;
        bus.is_branch_ID = br; bus.branch_taken_ID = tk;
        bus.rd_ID2EXE = de; bus.rd_EXE2MEM = dm; bus.Reg_W_En_ID2EXE = we; bus.Reg_W_En_EXE2MEM = wm;
        bus.Mem_R_En_ID2EXE = le; bus.Mem_R_En_EXE2MEM = lm; bus.dmem_req_EXE2MEM = rq; bus.dmem_ready = rd;
    endtask
    task automatic go(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask
    task automatic mid();
        @(negedge clk);
        #1;
    endtask
    task automatic idle();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask
    initial begin
        reset = 1'b1;
        idle();
        go(2);
        mid();
        chk("rst pc_we", 32'(bus.pc_we), 0);
        chk("rst IF2ID_flush", 32'(bus.IF2ID_flush), 1);
        chk("rst stall_cycles", 32'(bus.stall_cycles), 0);
        chk("rst mem_timeout", 32'(bus.mem_timeout), 0);
        go(1);
        reset = 1'b0;
        go(1);
        // lw x5 in EXE, add x6,x5,x1 in ID
        drv(5, 1, 1, 1, 0, 0, 5, 0, 1, 0, 1, 0, 0, 0);
        mid();
        chk("lu pc_we", 32'(bus.pc_we), 0);
        chk("lu ID2EXE_bubble", 32'(bus.ID2EXE_bubble), 1);
        chk("lu EXE2MEM_we", 32'(bus.EXE2MEM_we), 1);
        go(1);
        drv(5, 1, 1, 1, 0, 0, 0, 5, 0, 1, 0, 1, 0, 0);
        mid();
        chk("lu after stall_cycles", 32'(bus.stall_cycles), 1);
        chk("lu after pc_we", 32'(bus.pc_we), 1);
        go(1);
        // lw x7 then beq x7,x0 taken: two stalls then flush
        drv(7, 0, 1, 1, 1, 1, 7, 0, 1, 0, 1, 0, 0, 0);
        mid();
        chk("br1 pc_we", 32'(bus.pc_we), 0);
        chk("br1 IF2ID_flush", 32'(bus.IF2ID_flush), 0);
        go(1);
        drv(7, 0, 1, 1, 1, 1, 0, 7, 0, 1, 0, 1, 0, 0);
        mid();
        chk("br2 pc_we", 32'(bus.pc_we), 0);
        go(1);
        drv(7, 0, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        mid();
        chk("br3 IF2ID_flush", 32'(bus.IF2ID_flush), 1);
        chk("br3 stall_cycles", 32'(bus.stall_cycles), 3);
        go(1);
        idle();
        mid();
        chk("br flush_count", 32'(bus.flush_count), 1);
        go(1);
        // addi x3 in EXE, beq x3,x4 taken: no stall
        drv(3, 4, 1, 1, 1, 1, 3, 0, 1, 0, 0, 0, 0, 0);
        mid();
        chk("alu IF2ID_flush", 32'(bus.IF2ID_flush), 1);
        chk("alu pc_we", 32'(bus.pc_we), 1);
        go(1);
        // x0 and unused operand filtering
        drv(0, 0, 1, 1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0);
        mid();
        chk("x0 pc_we", 32'(bus.pc_we), 1);
        go(1);
        drv(2, 9, 1, 0, 0, 0, 9, 0, 1, 0, 1, 0, 0, 0);
        go(1);
        drv(2, 9, 1, 0, 1, 0, 0, 9, 0, 1, 0, 1, 0, 0);
        mid();
        chk("unused rs2 ID2EXE_bubble", 32'(bus.ID2EXE_bubble), 0);
        go(1);
        // 4-cycle memory wait with a concurrent load-use
        drv(5, 1, 1, 1, 0, 0, 5, 0, 1, 0, 1, 0, 1, 0);
        mid();
        chk("mw pc_we", 32'(bus.pc_we), 0);
        chk("mw MEM2WB_bubble", 32'(bus.MEM2WB_bubble), 1);
        chk("mw ID2EXE_bubble", 32'(bus.ID2EXE_bubble), 0);
        go(4);
        drv(5, 1, 1, 1, 0, 0, 5, 0, 1, 0, 1, 0, 1, 1);
        mid();
        chk("mw memwait_cycles", 32'(bus.memwait_cycles), 4);
        chk("mw release ID2EXE_bubble", 32'(bus.ID2EXE_bubble), 1);
        chk("mw release MEM2WB_bubble", 32'(bus.MEM2WB_bubble), 0);
        go(1);
        // single-cycle access: no freeze
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        mid();
        chk("1cyc MEM2WB_bubble", 32'(bus.MEM2WB_bubble), 0);
        go(1);
        // hold load-use long enough to saturate stall_cycles
        drv(5, 1, 1, 1, 0, 0, 5, 0, 1, 0, 1, 0, 0, 0);
        go(12);
        idle();
        mid();
        chk("sat stall_cycles", 32'(bus.stall_cycles), MAX);
        go(1);
        // timeout after TO wait cycles, sticky and frozen
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        go(7);
        mid();
        chk("pre timeout", 32'(bus.mem_timeout), 0);
        go(1);
        mid();
        chk("timeout set", 32'(bus.mem_timeout), 1);
        go(1);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        mid();
        chk("timeout frozen pc_we", 32'(bus.pc_we), 0);
        go(3);
        mid();
        chk("timeout sticky", 32'(bus.mem_timeout), 1);
        chk("sat memwait_cycles", 32'(bus.memwait_cycles), MAX);
        go(1);
        reset = 1'b1;
        go(1);
        reset = 1'b0;
        drv(5, 1, 1, 1, 0, 0, 5, 0, 1, 0, 1, 0, 0, 0);
        mid();
        chk("post rst mem_timeout", 32'(bus.mem_timeout), 0);
        chk("post rst memwait_cycles", 32'(bus.memwait_cycles), 0);
        chk("post rst ID2EXE_bubble", 32'(bus.ID2EXE_bubble), 1);
        go(1);
        idle();
        go(2);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
